// File: rtl/data_bus_ctrl.sv
// data_bus_ctrl: data-side bus controller behind the CPU MEM stage.
// Decodes each access to data RAM, GPIO (LED/switch), a 32-bit timer or a
// UART transmitter. Load data is a zero-latency mux on the current address.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cpu_addr/wdata/we MEM-stage byte address, store data, store strobe
//   cpu_rdata         combinational load data
//   ram_addr/wdata/we data RAM write side (we gated by RAM hit)
//   ram_rdata         asynchronous-read RAM data
//   sw / led          switch inputs (synchronised) / LED register
//   uart_tx           8N1 serial line, idle high
//   bus_err           sticky flag: an unmapped address was presented
module data_bus_ctrl #(
  parameter int RAM_AW  = 10,
  parameter int CLK_DIV = 868,
  parameter int GPIO_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_we,
  output logic [31:0]       cpu_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  input  logic [31:0]       ram_rdata,
  input  logic [GPIO_W-1:0] sw,
  output logic [GPIO_W-1:0] led,
  output logic              uart_tx,
  output logic              bus_err
);

  localparam logic [31:0] A_LED  = 32'hFFFF_0000;
  localparam logic [31:0] A_SW   = 32'hFFFF_0004;
  localparam logic [31:0] A_TCNT = 32'hFFFF_0008;
  localparam logic [31:0] A_TCMP = 32'hFFFF_000C;
  localparam logic [31:0] A_UTX  = 32'hFFFF_0010;
  localparam logic [31:0] A_STAT = 32'hFFFF_0014;

  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [31:0]       aw;
  logic              hit_ram, hit_led, hit_sw, hit_tcnt, hit_tcmp, hit_utx, hit_stat;
  logic              unmapped;
  logic [GPIO_W-1:0] sw_p0, sw_p1;
  logic [31:0]       tcnt, tcmp;
  logic              tmatch;
  logic              busy;

  state_t            state, state_nx;
  logic [BW-1:0]     baud, baud_nx;
  logic [2:0]        bitcnt, bitcnt_nx;
  logic [7:0]        shreg, shreg_nx;

  // Byte offset within a word is ignored: mask it rather than slice it off.
  assign aw       = cpu_addr & 32'hFFFF_FFFC;
  assign hit_ram  = (cpu_addr[31:RAM_AW+2] == '0);
  assign hit_led  = (aw == A_LED);
  assign hit_sw   = (aw == A_SW);
  assign hit_tcnt = (aw == A_TCNT);
  assign hit_tcmp = (aw == A_TCMP);
  assign hit_utx  = (aw == A_UTX);
  assign hit_stat = (aw == A_STAT);
  assign unmapped = ~(hit_ram | hit_led | hit_sw | hit_tcnt |
                      hit_tcmp | hit_utx | hit_stat);

  assign ram_addr  = cpu_addr[RAM_AW+1:2];
  assign ram_wdata = cpu_wdata;
  assign ram_we    = cpu_we & hit_ram;

  assign busy = (state != IDLE);

  always_comb begin
    cpu_rdata = 32'h0;
    if (hit_ram)       cpu_rdata = ram_rdata;
    else if (hit_led)  cpu_rdata = 32'(led);
    else if (hit_sw)   cpu_rdata = 32'(sw_p1);
    else if (hit_tcnt) cpu_rdata = tcnt;
    else if (hit_tcmp) cpu_rdata = tcmp;
    else if (hit_stat) cpu_rdata = {30'h0, tmatch, busy};
  end

  // Register stage: GPIO, timer, sticky error, switch synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      led     <= '0;
      tcnt    <= 32'h0;
      tcmp    <= 32'hFFFF_FFFF;
      tmatch  <= 1'b0;
      bus_err <= 1'b0;
      sw_p0   <= '0;
      sw_p1   <= '0;
    end else begin
      sw_p0 <= sw;
      sw_p1 <= sw_p0;
      if (cpu_we && hit_led) led <= cpu_wdata[GPIO_W-1:0];
      tcnt <= (cpu_we && hit_tcnt) ? cpu_wdata : tcnt + 32'd1;
      if (cpu_we && hit_tcmp) tmatch <= tmatch;
      if (cpu_we && hit_tcmp) tcmp <= cpu_wdata;
      // A coincident match beats a software clear.
      if (tcnt == tcmp)
        tmatch <= 1'b1;
      else if (cpu_we && hit_stat && cpu_wdata[1])
        tmatch <= 1'b0;
      if (unmapped) bus_err <= 1'b1;
    end
  end

  // Register stage: UART TX state
  always_ff @(posedge clk) begin
    shreg <= shreg_nx;
    if (rst) begin
      state  <= IDLE;
      baud   <= '0;
      bitcnt <= '0;
    end else begin
      state  <= state_nx;
      baud   <= baud_nx;
      bitcnt <= bitcnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    baud_nx   = baud;
    bitcnt_nx = bitcnt;
    shreg_nx  = shreg;
    uart_tx   = 1'b1;
    case (state)
      IDLE: begin
        if (cpu_we && hit_utx) begin
          state_nx  = START;
          baud_nx   = '0;
          bitcnt_nx = '0;
          shreg_nx  = cpu_wdata[7:0];
        end
      end
      START: begin
        uart_tx = 1'b0;
        if (baud == BAUD_LAST) begin
          state_nx = DATA;
          baud_nx  = '0;
        end else begin
          baud_nx = baud + 1'b1;
        end
      end
      DATA: begin
        uart_tx = shreg[0];
        if (baud == BAUD_LAST) begin
          baud_nx = '0;
          if (bitcnt == 3'd7) begin
            state_nx = STOP;
          end else begin
            bitcnt_nx = bitcnt + 3'd1;
            shreg_nx  = {1'b0, shreg[7:1]};
          end
        end else begin
          baud_nx = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          state_nx = IDLE;
          baud_nx  = '0;
        end else begin
          baud_nx = baud + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/data_bus_ctrl.md
Name: data_bus_ctrl

Overview:
- Data-side bus controller directly downstream of the pipelined CPU's MEM-stage data port (address, write data, write enable, read data).
- Decodes each access to one of: data RAM, GPIO, a 32-bit timer, or a UART transmitter.
- Returns read data combinationally in the same cycle so the WB mux can capture it.
- Owns all peripheral state: LED register, timer counter and compare, match flag, and the UART TX state machine.

Parameters:
- RAM_AW, 10, word-address width of data RAM (RAM window = 4*2^RAM_AW bytes from 0x0000_0000)
- CLK_DIV, 868, clk cycles per UART bit (100 MHz / 115200)
- GPIO_W, 16, LED/switch width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cpu_addr  in  32  byte address from MEM stage
- cpu_wdata  in  32  store data
- cpu_we  in  1  store strobe; write commits at next posedge
- cpu_rdata  out  32  load data, combinational from cpu_addr
- ram_addr  out  RAM_AW  word address = cpu_addr[RAM_AW+1:2]
- ram_wdata  out  32  = cpu_wdata
- ram_we  out  1  cpu_we gated by RAM hit
- ram_rdata  in  32  asynchronous-read RAM data
- sw  in  GPIO_W  asynchronous switches
- led  out  GPIO_W  LED register
- uart_tx  out  1  serial line, 8N1, idle high
- bus_err  out  1  sticky: unmapped access seen

Behaviour:
- Address map (word-aligned; cpu_addr[1:0] ignored):
  - RAM hit: cpu_addr[31:RAM_AW+2] == 0.
  - 0xFFFF_0000 LED, RW.
  - 0xFFFF_0004 SW, RO; writes dropped.
  - 0xFFFF_0008 TCNT, RW.
  - 0xFFFF_000C TCMP, RW.
  - 0xFFFF_0010 UTX, WO; reads 0.
  - 0xFFFF_0014 STAT, RW: bit0 = uart_busy, bit1 = tmatch, other bits 0.
  - Anything else: unmapped.
- Reads:
  - Pure combinational mux on the decoded address; zero latency.
  - Unmapped reads return 0x0000_0000.
  - A read of any kind, mapped or not, never changes state. Exception: an unmapped read sets bus_err.
- Writes:
  - Take effect at the posedge where cpu_we=1.
  - The target register shows the new value in the following cycle.
  - Unmapped writes are dropped and set bus_err.
  - ram_we=0 for every non-RAM address.
- bus_err:
  - Any access to an unmapped address sets it, with or without cpu_we.
  - Stays set until rst.
- Reset values:
  - led=0, TCNT=0, TCMP=0xFFFF_FFFF, tmatch=0, bus_err=0.
  - uart_tx=1, UART state IDLE.
  - Switch synchroniser flops = 0.
- SW read: returns the output of a 2-flop synchroniser. Read value lags sw by 2 cycles.
- Timer:
  - TCNT increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.
  - A write to TCNT loads cpu_wdata; the load overrides the increment that cycle.
  - When TCNT == TCMP, tmatch is set at the next edge.
  - Writing STAT with bit1=1 clears tmatch. If a set and a clear coincide, set wins.
  - Writing STAT bit0 has no effect.
- UART TX FSM: states IDLE, START, DATA, STOP.
  - IDLE: line is 1. A UTX write loads cpu_wdata[7:0] into the shift register and enters START. busy goes to 1 in the next cycle.
  - START: drives 0 for CLK_DIV cycles.
  - DATA: drives 8 bits LSB-first, CLK_DIV cycles each. A 3-bit bit counter is used.
  - STOP: drives 1 for CLK_DIV cycles, then returns to IDLE. busy returns to 0 the cycle IDLE is entered.
  - A frame is 10*CLK_DIV cycles from the write edge to the end of STOP.
  - A UTX write while busy=1 is silently dropped; the frame in flight is not disturbed.
  - Baud counter counts 0..CLK_DIV-1 and restarts at each bit boundary.
- rst mid-operation: aborts a UART frame immediately (uart_tx=1 next cycle, IDLE) and clears all registers to their reset values.

Test Plan:
- Reset: hold rst 2 cycles -> led=0, uart_tx=1, bus_err=0, STAT reads 0, TCMP reads 0xFFFF_FFFF.
- RAM/GPIO routing:
  - Store 0x1234_5678 to 0x0000_0010 -> ram_we=1, ram_addr=4.
  - Store 0x0000_00A5 to 0xFFFF_0000 -> ram_we=0; led=0x00A5 next cycle; load 0xFFFF_0000 returns 0x0000_00A5.
  - Set sw=0x3C00 -> load 0xFFFF_0004 returns 0x0000_3C00 from the 3rd cycle on.
- Timer:
  - Write TCNT=0xFFFF_FFFE and TCMP=0x0000_0001 -> TCNT reads 0xFFFF_FFFF, then 0, then 1; STAT bit1=1 one cycle after TCNT==1.
  - Write STAT=0x2 -> bit1 reads 0.
- UART (CLK_DIV=4):
  - Write UTX=0x55 -> busy=1; uart_tx = 0 (4 cycles), then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 (4 cycles); busy=0 after 40 cycles.
  - A second write of 0xFF mid-frame is ignored.
- Unmapped: load 0x8000_0000 -> cpu_rdata=0, bus_err=1 and stays 1; a store to 0xFFFF_0004 leaves SW unchanged and bus_err unaffected by that store.
- Reset mid-frame: assert rst during the DATA bits of 0x0F -> uart_tx=1 and busy=0 next cycle; a new UTX write starts a clean frame.
